// File: rtl/param_reg_file_if.sv
// Register-file bus: read ports, write ports and the dump stream.
// The master drives addresses/writes/dump control; the slave is the register file.
interface param_reg_file_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned NR    = 4,
  parameter int unsigned NW    = 2
);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [NR*AW-1:0]   rd_num;
  logic [NR*XLEN-1:0] rd_data;
  logic [NW-1:0]      wr_en;
  logic [NW*AW-1:0]   wr_num;
  logic [NW*XLEN-1:0] wr_data;
  logic               dump_req;
  logic               dump_valid;
  logic               dump_ready;
  logic [AW-1:0]      dump_idx;
  logic [XLEN-1:0]    dump_data;
  logic               dump_last;
  logic               busy;

  modport master (
    output rd_num, wr_en, wr_num, wr_data, dump_req, dump_ready,
    input  rd_data, dump_valid, dump_idx, dump_data, dump_last, busy
  );

  modport slave (
    input  rd_num, wr_en, wr_num, wr_data, dump_req, dump_ready,
    output rd_data, dump_valid, dump_idx, dump_data, dump_last, busy
  );
endinterface

// File: rtl/param_reg_file.sv
// Multi-ported register file with optional write-to-read bypass, optional
// hardwired-zero register 0, and a ready/valid dump stream that freezes the
// contents while it walks every register in order.
module param_reg_file #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned NR       = 4,
  parameter int unsigned NW       = 2,
  parameter int unsigned BYPASS   = 1,
  parameter int unsigned ZERO_REG = 0
) (
  input logic             clk,
  input logic             rst_b,
  param_reg_file_if.slave bus
);
  localparam int unsigned AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DepthW  = (AW + 1)'(DEPTH);
  localparam logic [AW-1:0] LastIdx = AW'(DEPTH - 1);

  typedef enum logic [0:0] {
    StIdle,
    StDump
  } state_e;

  logic [XLEN-1:0] r_regs      [DEPTH];
  logic [XLEN-1:0] w_regs_next [DEPTH];
  state_e          r_state;
  state_e          w_state_next;
  logic [AW-1:0]   r_idx;
  logic [AW-1:0]   w_idx_next;
  logic            w_busy;
  logic [NW-1:0]   w_wr_ok;
  logic [AW-1:0]   w_rd_addr   [NR];
  logic [XLEN-1:0] w_rd_val    [NR];

  // Addresses past DEPTH exist only when DEPTH is not a power of two.
  function automatic logic in_range(input logic [AW-1:0] a);
    return {1'b0, a} < DepthW;
  endfunction

  function automatic logic is_zero_reg(input logic [AW-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  assign w_busy = (r_state == StDump);

  // Qualify each write port: not dumping, in range, not the hardwired zero.
  always_comb begin
    w_wr_ok = '0;
    for (int w = 0; w < NW; w++) begin
      w_wr_ok[w] = bus.wr_en[w] && !w_busy
                   && in_range(bus.wr_num[w*AW +: AW])
                   && !is_zero_reg(bus.wr_num[w*AW +: AW]);
    end
  end

  // Apply ports in ascending order so the highest-numbered port wins a clash.
  always_comb begin
    w_regs_next = r_regs;
    for (int w = 0; w < NW; w++) begin
      if (w_wr_ok[w]) begin
        w_regs_next[bus.wr_num[w*AW +: AW]] = bus.wr_data[w*XLEN +: XLEN];
      end
    end
  end

  // Register storage, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      r_regs <= w_regs_next;
    end
  end

  // Combinational read ports with optional forwarding of this cycle's writes.
  always_comb begin
    bus.rd_data = '0;
    for (int r = 0; r < NR; r++) begin
      w_rd_addr[r] = bus.rd_num[r*AW +: AW];
      w_rd_val[r]  = '0;
    end
    for (int r = 0; r < NR; r++) begin
      if (in_range(w_rd_addr[r])) begin
        w_rd_val[r] = r_regs[w_rd_addr[r]];
      end
      // w_wr_ok already excludes busy, out-of-range and zero-register writes.
      if ((BYPASS != 0) && rst_b) begin
        for (int w = 0; w < NW; w++) begin
          if (w_wr_ok[w] && (bus.wr_num[w*AW +: AW] == w_rd_addr[r])) begin
            w_rd_val[r] = bus.wr_data[w*XLEN +: XLEN];
          end
        end
      end
      if (is_zero_reg(w_rd_addr[r])) begin
        w_rd_val[r] = '0;
      end
      bus.rd_data[r*XLEN +: XLEN] = w_rd_val[r];
    end
  end

  // Dump FSM state and beat index.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_state <= StIdle;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_next;
      r_idx   <= w_idx_next;
    end
  end

  // Dump next-state: start on request, advance only on an accepted beat.
  always_comb begin
    w_state_next = r_state;
    w_idx_next   = r_idx;
    unique case (r_state)
      StIdle: begin
        if (bus.dump_req) begin
          w_state_next = StDump;
          w_idx_next   = '0;
        end
      end
      StDump: begin
        if (bus.dump_ready) begin
          if (r_idx == LastIdx) begin
            w_state_next = StIdle;
            w_idx_next   = '0;
          end else begin
            w_idx_next = r_idx + 1'b1;
          end
        end
      end
      default: begin
        w_state_next = StIdle;
        w_idx_next   = '0;
      end
    endcase
  end

  // Dump outputs; all zero outside a dump.
  always_comb begin
    bus.busy       = w_busy;
    bus.dump_valid = w_busy;
    bus.dump_idx   = '0;
    bus.dump_data  = '0;
    bus.dump_last  = 1'b0;
    if (w_busy) begin
      bus.dump_idx  = r_idx;
      bus.dump_data = is_zero_reg(r_idx) ? '0 : r_regs[r_idx];
      bus.dump_last = (r_idx == LastIdx);
    end
  end
endmodule

// File: doc/param_reg_file.md
PARAM_REG_FILE -- requirements
Module: param_reg_file

Interface
REQ-001 Parameter XLEN, default 32: register width in bits.
REQ-002 Parameter DEPTH, default 16: number of registers; AW = clog2(DEPTH).
REQ-003 Parameter NR, default 4: number of read ports.
REQ-004 Parameter NW, default 2: number of write ports.
REQ-005 Parameter BYPASS, default 1: 1 = same-cycle write-to-read forwarding.
REQ-006 Parameter ZERO_REG, default 0: 1 = register 0 is hardwired to zero.
REQ-007 clk  input  1  sole clock; all state updates on rising edge.
REQ-008 rst_b  input  1  reset, asynchronous assert, active-low.
REQ-009 rd_num  input  NR*AW  read addresses; port i at bits [i*AW +: AW].
REQ-010 rd_data  output  NR*XLEN  read data; port i at bits [i*XLEN +: XLEN].
REQ-011 wr_en  input  NW  per-port write enable.
REQ-012 wr_num  input  NW*AW  write addresses, packed as rd_num.
REQ-013 wr_data  input  NW*XLEN  write data, packed as rd_data.
REQ-014 dump_req  input  1  single-cycle request to stream out all registers.
REQ-015 dump_valid  output  1  dump beat valid.
REQ-016 dump_ready  input  1  consumer accepts the dump beat.
REQ-017 dump_idx  output  AW  register index of the current beat.
REQ-018 dump_data  output  XLEN  register contents of the current beat.
REQ-019 dump_last  output  1  current beat is index DEPTH-1.
REQ-020 busy  output  1  dump in progress; writes are blocked.

Function
REQ-021 Reads are combinational: rd_data[i] = reg[rd_num[i]], or 0 when ZERO_REG=1 and rd_num[i]=0.
REQ-022 Each write port with wr_en=1 and busy=0 updates reg[wr_num] on the next rising edge; every enabled port is applied independently, with no cross-port gating.
REQ-023 Same-address write conflict: highest-numbered enabled port wins.
REQ-024 When ZERO_REG=1, writes to index 0 are discarded.
REQ-025 When BYPASS=1 and busy=0, a read whose address matches an enabled write port returns that write's wr_data in the same cycle; REQ-023 priority applies; ZERO_REG masking overrides bypass.
REQ-026 When BYPASS=0, reads return the pre-edge stored value.
REQ-027 Out-of-range addresses (>= DEPTH, non-power-of-two DEPTH) read 0 and discard writes.
REQ-028 Dump FSM has states IDLE and DUMP; reset state is IDLE.
REQ-029 IDLE -> DUMP on dump_req=1; dump index loads 0; busy=1 from the next cycle.
REQ-030 In DUMP: dump_valid=1, dump_idx = index, dump_data = reg[index] (0 for index 0 when ZERO_REG=1).
REQ-031 In DUMP, the index advances by 1 only on dump_valid & dump_ready; dump_idx and dump_data hold stable while dump_ready=0.
REQ-032 When the beat with dump_last=1 is accepted, the FSM returns to IDLE and busy=0 from the next cycle.
REQ-033 dump_req is ignored while in DUMP.
REQ-034 While busy=1, wr_en is ignored, register contents are frozen, and bypass is disabled.
REQ-035 Writes presented in the same cycle as the accepted dump_req are applied, and the dump sees the updated values.
REQ-036 In IDLE: dump_valid=0, dump_last=0, dump_idx=0, dump_data=0.

Reset
REQ-037 While rst_b=0, all registers are cleared to 0, the FSM is forced to IDLE, and busy=0, dump_valid=0, dump_last=0, dump_idx=0, dump_data=0; rd_data reads 0.
REQ-038 Reset asserted mid-dump aborts the dump immediately, with no further beats after release.
REQ-039 After rst_b deasserts, the first rising edge performs normal writes.

Verification
REQ-040 Reset, then write port0 r3=0x11111111 and port1 r5=0x22222222 in one cycle -> next cycle, read ports 0..3 at r3/r5/r0/r15 return 0x11111111/0x22222222/0/0.
REQ-041 Both ports write r7 (port0 0xAAAA0000, port1 0x0000BBBB) with a read port on r7, BYPASS=1 -> same cycle reads 0x0000BBBB; after the edge r7 = 0x0000BBBB.
REQ-042 ZERO_REG=1: write r0=0xFFFFFFFF with a same-cycle read of r0 -> reads 0 in that cycle and after.
REQ-043 Preload r0..r15 with values 0x100+i, pulse dump_req, and drop dump_ready on beats 4-6 -> 16 beats idx 0..15, data 0x100+idx, each held while stalled, dump_last only on idx 15, busy clears after the final accept.
REQ-044 During the dump, write r2=0xDEAD -> r2 is unchanged at the end and the dump shows the original value.
REQ-045 Assert rst_b=0 at dump beat 8 -> dump_valid and busy drop at once, all registers read 0, and no further beats follow.
